// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline types for the writeback stage.
//   ld_op_e   - 3-bit load operation encoding (also used by MEM store alignment)
//   DATA_W    - default register/data width
//   ADDR_W    - default register address width
//   wb_slot_t - contents of the single WB slot register
// Optional feature macro: WB_HILO_EN adds the HI/LO request fields to the slot.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } ld_op_e;

    typedef struct packed {
        logic              valid;
        logic              wreg;
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] wdata;
        ld_op_e            ld_op;
        logic [1:0]        addr_lo;
        logic [DATA_W-1:0] rt;
`ifdef WB_HILO_EN
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
`endif
    } wb_slot_t;

    // Sign-extend a byte to the data width.
    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

    // Sign-extend a halfword to the data width.
    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h);
        return {{(DATA_W-16){h[15]}}, h};
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM->WB handshake and register-file write port bundle.
//   master : pipeline side (drives stall/flush and mem_* fields, reads write port)
//   slave  : wb_stage side (reads mem_* fields, drives we/waddr/wdata/wb_valid)
// Optional feature macro: WB_HILO_EN adds mem_whilo/mem_hi/mem_lo and hi_o/lo_o.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   stall_i;
    logic                   flush_i;
    logic                   mem_valid;
    logic                   mem_wreg;
    logic [ADDR_W-1:0]      mem_wd;
    logic [DATA_W-1:0]      mem_wdata;
    cpu_pkg::ld_op_e        mem_ld_op;
    logic [1:0]             mem_addr_lo;
    logic [DATA_W-1:0]      mem_rt;
`ifdef WB_HILO_EN
    logic                   mem_whilo;
    logic [DATA_W-1:0]      mem_hi;
    logic [DATA_W-1:0]      mem_lo;
    logic [DATA_W-1:0]      hi_o;
    logic [DATA_W-1:0]      lo_o;
`endif
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic                   wb_valid;

    modport master (
        output stall_i, flush_i, mem_valid, mem_wreg, mem_wd, mem_wdata,
               mem_ld_op, mem_addr_lo, mem_rt,
`ifdef WB_HILO_EN
        output mem_whilo, mem_hi, mem_lo,
        input  hi_o, lo_o,
`endif
        input  we, waddr, wdata, wb_valid
    );

    modport slave (
        input  stall_i, flush_i, mem_valid, mem_wreg, mem_wd, mem_wdata,
               mem_ld_op, mem_addr_lo, mem_rt,
`ifdef WB_HILO_EN
        input  mem_whilo, mem_hi, mem_lo,
        output hi_o, lo_o,
`endif
        output we, waddr, wdata, wb_valid
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load data alignment (little-endian).
//   ld_op   - load operation
//   addr_lo - byte offset of the access
//   mem     - raw loaded word (or ALU result for LD_NONE)
//   rt      - old rt value merged by LWL/LWR
//   wdata   - aligned, extended register write data
module load_align
    import cpu_pkg::*;
(
    input  ld_op_e            ld_op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] rt,
    output logic [DATA_W-1:0] wdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword; halfword ignores addr_lo[0].
    always_comb begin
        byte_s = mem[{addr_lo, 3'b000} +: 8];
        if (addr_lo[1]) begin
            half_s = mem[31:16];
        end else begin
            half_s = mem[15:0];
        end
    end

    // Per-op result; LWL/LWR merge memory bytes with rt by offset.
    always_comb begin
        wdata = mem;
        case (ld_op)
            LD_NONE: wdata = mem;
            LD_LB:   wdata = sext8(byte_s);
            LD_LBU:  wdata = {24'h00_0000, byte_s};
            LD_LH:   wdata = sext16(half_s);
            LD_LHU:  wdata = {16'h0000, half_s};
            LD_LW:   wdata = mem;
            LD_LWL: begin
                case (addr_lo)
                    2'd0:    wdata = {mem[7:0],  rt[23:0]};
                    2'd1:    wdata = {mem[15:0], rt[15:0]};
                    2'd2:    wdata = {mem[23:0], rt[7:0]};
                    2'd3:    wdata = mem;
                    default: wdata = mem;
                endcase
            end
            LD_LWR: begin
                case (addr_lo)
                    2'd0:    wdata = mem;
                    2'd1:    wdata = {rt[31:24], mem[31:8]};
                    2'd2:    wdata = {rt[31:16], mem[31:16]};
                    2'd3:    wdata = {rt[31:8],  mem[31:24]};
                    default: wdata = mem;
                endcase
            end
            default: wdata = mem;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered MEM->WB boundary and register-file write port.
//   clk   - pipeline clock
//   rst   - asynchronous reset, active-low
//   bus   - wb_stage_if.slave: stall/flush, mem_* capture fields,
//           we/waddr/wdata/wb_valid write port (also the WB forwarding source)
// Optional feature macro: WB_HILO_EN - owns the HI/LO register pair with
// bypassed hi_o/lo_o read outputs.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
)(
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);

    wb_slot_t          slot_r;
    wb_slot_t          next_s;
    logic [DATA_W-1:0] aligned_s;
    logic [ADDR_W-1:0] waddr_s;

    // Gather the MEM-stage fields into the slot format.
    always_comb begin
        next_s         = '0;
        next_s.valid   = bus.mem_valid;
        next_s.wreg    = bus.mem_wreg;
        next_s.wd      = bus.mem_wd;
        next_s.wdata   = bus.mem_wdata;
        next_s.ld_op   = bus.mem_ld_op;
        next_s.addr_lo = bus.mem_addr_lo;
        next_s.rt      = bus.mem_rt;
`ifdef WB_HILO_EN
        next_s.whilo   = bus.mem_whilo;
        next_s.hi      = bus.mem_hi;
        next_s.lo      = bus.mem_lo;
`endif
    end

    // WB slot: flush beats stall; flush only needs to kill valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_r <= '0;
        end else if (bus.flush_i) begin
            slot_r.valid <= 1'b0;
        end else if (bus.stall_i) begin
            slot_r <= slot_r;
        end else begin
            slot_r <= next_s;
        end
    end

    load_align u_align (
        .ld_op   (slot_r.ld_op),
        .addr_lo (slot_r.addr_lo),
        .mem     (slot_r.wdata),
        .rt      (slot_r.rt),
        .wdata   (aligned_s)
    );

    assign waddr_s      = slot_r.wd;
    assign bus.we       = slot_r.valid & slot_r.wreg;
    assign bus.waddr    = waddr_s;
    assign bus.wdata    = aligned_s;
    assign bus.wb_valid = slot_r.valid;

`ifdef WB_HILO_EN
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;

    // HI/LO commit: a stalled slot keeps re-presenting, so commit waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (slot_r.valid & slot_r.whilo & !bus.stall_i) begin
            hi_r <= slot_r.hi;
            lo_r <= slot_r.lo;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Read bypass: an in-flight HI/LO write is visible before it commits.
    always_comb begin
        if (slot_r.valid & slot_r.whilo) begin
            bus.hi_o = slot_r.hi;
            bus.lo_o = slot_r.lo;
        end else begin
            bus.hi_o = hi_r;
            bus.lo_o = lo_r;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
// A behavioural model of the WB slot (plain arithmetic for alignment) is
// compared against the DUT every cycle; directed steps add literal checks.
// Builds with or without WB_HILO_EN.
module tb_wb_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic        m_wreg  = 1'b0;
    logic [4:0]  m_wd    = 5'd0;
    logic [31:0] m_data  = 32'd0;
    ld_op_e      m_op    = LD_NONE;
    int          m_k     = 0;
    logic [31:0] m_rt    = 32'd0;
`ifdef WB_HILO_EN
    logic        m_whilo = 1'b0;
    logic [31:0] m_shi = 32'd0, m_slo = 32'd0;
    logic [31:0] m_hi  = 32'd0, m_lo  = 32'd0;
`endif

    function automatic logic [31:0] model_wdata(ld_op_e op, int k, logic [31:0] mem, logic [31:0] rt);
        logic [31:0] b, h;
        int sh;
        b = (mem >> (8 * k)) & 32'h0000_00FF;
        h = (mem >> (16 * (k / 2))) & 32'h0000_FFFF;
        case (op)
            LD_LB:   return (b > 32'd127) ? (b | 32'hFFFF_FF00) : b;
            LD_LBU:  return b;
            LD_LH:   return (h > 32'd32767) ? (h | 32'hFFFF_0000) : h;
            LD_LHU:  return h;
            LD_LWL: begin
                sh = 8 * (3 - k);
                return (mem << sh) | (rt & ((32'd1 << sh) - 32'd1));
            end
            LD_LWR: begin
                sh = 8 * k;
                return (mem >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            end
            default: return mem;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0; m_wreg <= 1'b0; m_wd <= 5'd0; m_data <= 32'd0;
            m_op <= LD_NONE; m_k <= 0; m_rt <= 32'd0;
`ifdef WB_HILO_EN
            m_whilo <= 1'b0; m_shi <= 32'd0; m_slo <= 32'd0; m_hi <= 32'd0; m_lo <= 32'd0;
`endif
        end else begin
`ifdef WB_HILO_EN
            if (m_valid && m_whilo && !bus.stall_i) begin
                m_hi <= m_shi;
                m_lo <= m_slo;
            end
`endif
            if (bus.flush_i) begin
                m_valid <= 1'b0;
            end else if (!bus.stall_i) begin
                m_valid <= bus.mem_valid; m_wreg <= bus.mem_wreg; m_wd <= bus.mem_wd;
                m_data <= bus.mem_wdata; m_op <= bus.mem_ld_op; m_k <= int'(bus.mem_addr_lo);
                m_rt <= bus.mem_rt;
`ifdef WB_HILO_EN
                m_whilo <= bus.mem_whilo; m_shi <= bus.mem_hi; m_slo <= bus.mem_lo;
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #2;
        chk("cyc_wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_valid});
        chk("cyc_we", {31'd0, bus.we}, {31'd0, m_valid & m_wreg});
        if (m_valid) begin
            chk("cyc_waddr", {27'd0, bus.waddr}, {27'd0, m_wd});
            chk("cyc_wdata", bus.wdata, model_wdata(m_op, m_k, m_data, m_rt));
        end
`ifdef WB_HILO_EN
        chk("cyc_hi_o", bus.hi_o, (m_valid && m_whilo) ? m_shi : m_hi);
        chk("cyc_lo_o", bus.lo_o, (m_valid && m_whilo) ? m_slo : m_lo);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic w, input logic [4:0] wd, input logic [31:0] d,
                         input ld_op_e op, input logic [1:0] lo, input logic [31:0] rt);
        @(negedge clk);
        bus.mem_valid = v; bus.mem_wreg = w; bus.mem_wd = wd; bus.mem_wdata = d;
        bus.mem_ld_op = op; bus.mem_addr_lo = lo; bus.mem_rt = rt;
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic load_case(input string name, input ld_op_e op, input logic [1:0] lo,
                             input logic [31:0] mem, input logic [31:0] rt, input logic [31:0] exp);
        drive(1'b1, 1'b1, 5'd10, mem, op, lo, rt);
        step();
        chk(name, bus.wdata, exp);
    endtask

    initial begin
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
`ifdef WB_HILO_EN
        bus.mem_whilo = 1'b0; bus.mem_hi = 32'd0; bus.mem_lo = 32'd0;
`endif
        drive(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, LD_NONE, 2'd0, 32'd0);
        step(); step();
        chk("rst_we", {31'd0, bus.we}, 32'd0);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_waddr", {27'd0, bus.waddr}, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);

        // ALU write, then asynchronous reset mid-cycle
        drive(1'b1, 1'b1, 5'd5, 32'h1234_5678, LD_NONE, 2'd0, 32'd0);
        rst = 1'b1;
        step();
        chk("alu_we", {31'd0, bus.we}, 32'd1);
        chk("alu_waddr", {27'd0, bus.waddr}, 32'd5);
        chk("alu_wdata", bus.wdata, 32'h1234_5678);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, bus.we}, 32'd0);
        chk("async_rst_wdata", bus.wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // byte/halfword extension
        load_case("lb_k1",   LD_LB,  2'd1, 32'h8899_AABB, 32'd0, 32'hFFFF_FFAA);
        load_case("lbu_k3",  LD_LBU, 2'd3, 32'h8899_AABB, 32'd0, 32'h0000_0088);
        load_case("lh_a2",   LD_LH,  2'd2, 32'h8899_AABB, 32'd0, 32'hFFFF_8899);
        load_case("lhu_a0",  LD_LHU, 2'd0, 32'h8899_AABB, 32'd0, 32'h0000_AABB);
        load_case("lh_a3",   LD_LH,  2'd3, 32'h0123_F456, 32'd0, 32'h0000_0123);
        load_case("lw_a2",   LD_LW,  2'd2, 32'h8899_AABB, 32'd0, 32'h8899_AABB);
        // unaligned merges
        load_case("lwl_k0",  LD_LWL, 2'd0, 32'h4433_2211, 32'hDDCC_BBAA, 32'h11CC_BBAA);
        load_case("lwl_k2",  LD_LWL, 2'd2, 32'h4433_2211, 32'hDDCC_BBAA, 32'h3322_11AA);
        load_case("lwl_k3",  LD_LWL, 2'd3, 32'h4433_2211, 32'hDDCC_BBAA, 32'h4433_2211);
        load_case("lwr_k0",  LD_LWR, 2'd0, 32'h4433_2211, 32'hDDCC_BBAA, 32'h4433_2211);
        load_case("lwr_k1",  LD_LWR, 2'd1, 32'h4433_2211, 32'hDDCC_BBAA, 32'hDD44_3322);
        load_case("lwr_k3",  LD_LWR, 2'd3, 32'h4433_2211, 32'hDDCC_BBAA, 32'hDDCC_BB44);

        // stall holds outputs while new MEM data is presented
        drive(1'b1, 1'b1, 5'd7, 32'hCAFE_F00D, LD_NONE, 2'd0, 32'd0);
        step();
        drive(1'b1, 1'b1, 5'd9, 32'h1111_1111, LD_LB, 2'd2, 32'd0);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_we", {31'd0, bus.we}, 32'd1);
            chk("stall_waddr", {27'd0, bus.waddr}, 32'd7);
            chk("stall_wdata", bus.wdata, 32'hCAFE_F00D);
        end
        // flush and stall together: flush wins
        drive(1'b1, 1'b1, 5'd3, 32'hAAAA_5555, LD_NONE, 2'd0, 32'd0);
        bus.flush_i = 1'b1;
        step();
        chk("flush_stall_we", {31'd0, bus.we}, 32'd0);
        chk("flush_stall_valid", {31'd0, bus.wb_valid}, 32'd0);

        // invalid slot suppresses write; r0 write emitted as-is
        drive(1'b0, 1'b1, 5'd4, 32'h0000_0004, LD_NONE, 2'd0, 32'd0);
        bus.flush_i = 1'b0; bus.stall_i = 1'b0;
        step();
        chk("novalid_we", {31'd0, bus.we}, 32'd0);
        drive(1'b1, 1'b1, 5'd0, 32'h0000_0005, LD_NONE, 2'd0, 32'd0);
        step();
        chk("r0_we", {31'd0, bus.we}, 32'd1);
        chk("r0_waddr", {27'd0, bus.waddr}, 32'd0);

`ifdef WB_HILO_EN
        drive(1'b1, 1'b0, 5'd0, 32'd0, LD_NONE, 2'd0, 32'd0);
        bus.mem_whilo = 1'b1; bus.mem_hi = 32'h0000_000A; bus.mem_lo = 32'h0000_000B;
        step();
        chk("hi_bypass", bus.hi_o, 32'h0000_000A);
        chk("lo_bypass", bus.lo_o, 32'h0000_000B);
        drive(1'b0, 1'b0, 5'd0, 32'd0, LD_NONE, 2'd0, 32'd0);
        bus.mem_whilo = 1'b0;
        step();
        chk("hi_commit", bus.hi_o, 32'h0000_000A);
        chk("lo_commit", bus.lo_o, 32'h0000_000B);
        drive(1'b1, 1'b0, 5'd0, 32'd0, LD_NONE, 2'd0, 32'd0);
        bus.mem_whilo = 1'b1; bus.mem_hi = 32'h0000_000C; bus.mem_lo = 32'h0000_000D;
        step();
        chk("hi_bypass2", bus.hi_o, 32'h0000_000C);
        drive(1'b0, 1'b0, 5'd0, 32'd0, LD_NONE, 2'd0, 32'd0);
        bus.mem_whilo = 1'b0; bus.stall_i = 1'b1; bus.flush_i = 1'b1;
        step();
        chk("hi_stalled_nocommit", bus.hi_o, 32'h0000_000A);
        chk("lo_stalled_nocommit", bus.lo_o, 32'h0000_000B);
        drive(1'b0, 1'b0, 5'd0, 32'd0, LD_NONE, 2'd0, 32'd0);
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        step();
        chk("hi_after_stall", bus.hi_o, 32'h0000_000A);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the in-order CPU pipeline: a registered MEM→WB boundary that captures the memory-stage result, aligns and sign-extends load data, and drives the register file write port (`we`/`waddr`/`wdata`). It optionally owns the architectural HI/LO register pair. It is the sole producer of register-file writes, and its write port also serves as the WB-stage forwarding source for decode.

## Interface
- `DATA_W`, 32, register/data width
- `ADDR_W`, 5, register address width
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous reset, active-low (asserted at 0)
- `stall_i`  in  1  hold WB contents; no new capture
- `flush_i`  in  1  discard the instruction captured this edge
- `mem_valid`  in  1  MEM slot holds an instruction
- `mem_wreg`  in  1  instruction writes a GPR
- `mem_wd`  in  ADDR_W  destination GPR
- `mem_wdata`  in  DATA_W  ALU result or raw loaded word
- `mem_ld_op`  in  3  `ld_op_e`: NONE, LB, LBU, LH, LHU, LW, LWL, LWR
- `mem_addr_lo`  in  2  load byte offset
- `mem_rt`  in  DATA_W  old rt value, used by LWL/LWR merge
- `mem_whilo`, `mem_hi`, `mem_lo`  in  1/DATA_W/DATA_W  HI/LO write request and data (only with `WB_HILO_EN`)
- `we`, `waddr`, `wdata`  out  1/ADDR_W/DATA_W  register file write port
- `wb_valid`  out  1  WB slot occupied
- `hi_o`, `lo_o`  out  DATA_W  HI/LO read values, bypassed (only with `WB_HILO_EN`)

## Operation
- One WB slot register holds: valid, wreg, wd, wdata, ld_op, addr_lo, rt, and, with `WB_HILO_EN`, whilo/hi/lo.
- Each rising edge, in priority order:
  - reset;
  - `flush_i` → valid := 0, other fields don't-care;
  - `stall_i` → hold all fields;
  - else capture all `mem_*` fields.
- `we = valid & wreg`. `waddr = wd`. Writes to r0 are emitted as-is; the regfile discards them.
- `wdata` is combinational from slot fields, little-endian. k = addr_lo.
  - NONE: wdata unchanged.
  - LB/LBU: byte k, sign- or zero-extended.
  - LH/LHU: halfword addr_lo[1], sign- or zero-extended; addr_lo[0] ignored.
  - LW: full word; addr_lo ignored.
  - LWL: mem bytes k..0 into the top k+1 bytes, rt fills the rest. k=0 → {mem[7:0], rt[23:0]}; k=3 → mem.
  - LWR: mem bytes 3..k into the low 4−k bytes, rt fills the rest. k=0 → mem; k=3 → {rt[31:8], mem[31:24]}.
- Misalignment is never flagged here; address exceptions are raised upstream.
- HI/LO (with macro): HI/LO registers are written on an edge where valid & whilo & !stall_i. `hi_o`/`lo_o` return the slot's hi/lo while valid & whilo, otherwise the registers.

## Timing
- Latency: MEM inputs captured at edge N appear on `we`/`waddr`/`wdata` during cycle N+1. Regfile commit happens at edge N+1.
- During a stall, `we` stays asserted with identical addr/data. Repeated writes are idempotent.
- `flush_i` and `stall_i` together → flush wins.
- Reset (async, `rst`=0) takes effect immediately, mid-cycle included:
  - valid=0, so `we`=0, `wb_valid`=0;
  - all slot fields 0, so `waddr`=0, `wdata`=0;
  - HI=LO=0, so `hi_o`=`lo_o`=0.
- Release of `rst` is synchronised externally; the first capture is on the first edge after release.
- A slot with `mem_valid`=0 captured gives `we`=0 regardless of wreg.

## Configuration
- `WB_HILO_EN` defined:
  - HI/LO registers, `mem_whilo`/`mem_hi`/`mem_lo` inputs and `hi_o`/`lo_o` outputs exist as above.
- Undefined:
  - those ports and registers are absent;
  - HI/LO live elsewhere;
  - all other behaviour is identical.

## Structure
- `cpu_pkg` holds `ld_op_e` (3-bit enum), `DATA_W`/`ADDR_W` defaults and the WB slot struct `wb_slot_t`.
- The combinational `load_align` sub-module (ld_op, addr_lo, mem word, rt → wdata) is instantiated once. Memory-stage store alignment reuses its enum only.

## Test plan
- Reset then capture ALU write (wreg=1, wd=5, wdata=0x1234_5678, NONE) → next cycle `we`=1, `waddr`=5, `wdata`=0x1234_5678; `rst`=0 mid-cycle → `we`=0 immediately.
- Word 0x8899_AABB: LB k=1 → 0xFFFF_FFAA; LBU k=3 → 0x0000_0088; LH addr_lo=2 → 0xFFFF_8899; LHU addr_lo=0 → 0x0000_AABB.
- LWL/LWR with mem=0x4433_2211, rt=0xDDCC_BBAA:
  - LWL k=0 → 0x11CC_BBAA; k=2 → 0x3322_11AA;
  - LWR k=1 → 0xDD44_3322; k=3 → 0xDDCC_BB44.
- Stall for 3 cycles with new MEM data presented → outputs hold original values. Flush+stall same edge → `we`=0 next cycle.
- `mem_valid`=0 with wreg=1 → `we`=0. Write to wd=0 → `we`=1, `waddr`=0.
- (`WB_HILO_EN`) whilo with hi=0xA, lo=0xB → `hi_o`/`lo_o` show 0xA/0xB in the WB cycle (bypass) and after commit. Same request under stall → registers unchanged until stall drops.
